// File: rtl/decode_out.sv
// LZS decoder output packer: gathers decoded bytes into 64-bit little-endian words.
// Optional DECODE_OUT_CRC_EN adds a CRC-32 over every accepted byte on port crc.
module decode_out #(
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned FO_WIDTH  = 64,
  parameter int unsigned LZF_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OUT_WIDTH-1:0] out_data,
  input  logic                 out_valid,
  input  logic                 all_end,
  output logic                 fo_full,
  output logic [FO_WIDTH-1:0]  m_dst,
  output logic                 m_dst_putn,
  input  logic                 m_dst_full,
  output logic                 m_dst_last,
  output logic [3:0]           m_dst_bytes,
  output logic [LZF_WIDTH-1:0] byte_cnt,
  output logic                 done,
  output logic                 overflow
`ifdef DECODE_OUT_CRC_EN
  ,
  output logic [31:0]          crc
`endif
);

  localparam int unsigned NBYTES   = FO_WIDTH / OUT_WIDTH;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned FULL_THR = 6;

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_LAST} state_e;

  typedef struct packed {
    logic [FO_WIDTH-1:0] word;
    logic [3:0]          bytes;
    logic                last;
    logic                valid;
  } hold_t;

  state_e               state_q, state_d;
  logic [FO_WIDTH-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  hold_t                hold_q, hold_d;
  logic [LZF_WIDTH-1:0] cnt_q, cnt_d;
  logic                 fo_full_q, fo_full_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic [31:0]          crc_q, crc_d;
  logic                 accept_c;
  logic                 hold_free_c;
  logic                 loaded;

  // Byte-serial reflected CRC-32 step; unused when the CRC option is off.
  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign accept_c    = hold_q.valid & ~m_dst_full;
  assign hold_free_c = ~hold_q.valid | accept_c;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    crc_d     = crc_q;
    done_d    = 1'b0;
    loaded    = 1'b0;
    fo_full_d = 1'b0;

    if (accept_c) hold_d.valid = 1'b0;
    // Counter and CRC restart on the edge that ends the done pulse.
    if (done_q) begin
      cnt_d = '0;
      crc_d = 32'hFFFFFFFF;
    end

    unique case (state_q)
      ST_RUN: begin
        // A full accumulator waiting on hold drains first, making room for a new byte.
        if (idx_q == IDX_W'(NBYTES) && hold_free_c) begin
          hold_d = '{word: acc_q, bytes: 4'd8, last: 1'b0, valid: 1'b1};
          acc_d  = '0;
          idx_d  = '0;
          loaded = 1'b1;
        end
        if (out_valid) begin
          if (idx_d == IDX_W'(NBYTES)) begin
            ovf_d = 1'b1;
          end else begin
            acc_d[{idx_d[2:0], 3'b000} +: 8] = out_data;
            idx_d = IDX_W'(idx_d + 4'd1);
            cnt_d = LZF_WIDTH'(cnt_d + 1'b1);
            crc_d = crc_step(crc_d, out_data);
          end
        end
        if (!loaded && idx_d == IDX_W'(NBYTES) && hold_free_c) begin
          hold_d = '{word: acc_d, bytes: 4'd8, last: 1'b0, valid: 1'b1};
          acc_d  = '0;
          idx_d  = '0;
        end
        if (all_end) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (out_valid) ovf_d = 1'b1;
        if (hold_free_c) begin
          hold_d  = '{word: acc_q, bytes: idx_q, last: 1'b1, valid: 1'b1};
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_LAST;
        end
      end
      ST_LAST: begin
        if (out_valid) ovf_d = 1'b1;
        if (accept_c && hold_q.last) begin
          done_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Two bytes of slack cover decode_ctl's one-cycle reaction to fo_full.
    fo_full_d = hold_d.valid & (idx_d >= IDX_W'(FULL_THR));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      acc_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      cnt_q     <= '0;
      fo_full_q <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      crc_q     <= 32'hFFFFFFFF;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      fo_full_q <= fo_full_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      crc_q     <= crc_d;
    end
  end

  assign m_dst_putn  = ~accept_c;
  assign m_dst       = hold_q.word;
  assign m_dst_last  = hold_q.last;
  assign m_dst_bytes = hold_q.bytes;
  assign byte_cnt    = cnt_q;
  assign fo_full     = fo_full_q;
  assign done        = done_q;
  assign overflow    = ovf_q;
`ifdef DECODE_OUT_CRC_EN
  assign crc         = ~crc_q;
`endif

endmodule

// File: tb/tb_decode_out.sv
// Scoreboard bench for decode_out: stimulus pushes expected words/done reports, a monitor pops them.
module tb_decode_out;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        all_end;
  logic        fo_full;
  logic [63:0] m_dst;
  logic        m_dst_putn;
  logic        m_dst_full;
  logic        m_dst_last;
  logic [3:0]  m_dst_bytes;
  logic [19:0] byte_cnt;
  logic        done;
  logic        overflow;
  logic [31:0] crc;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  bytes;
    logic        last;
  } word_t;

  typedef struct {
    logic [19:0] cnt;
    logic [31:0] crc;
    logic        crc_chk;
  } done_t;

  word_t word_q[$];
  done_t done_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  decode_out dut (
    .clk        (clk),
    .rst        (rst),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .all_end    (all_end),
    .fo_full    (fo_full),
    .m_dst      (m_dst),
    .m_dst_putn (m_dst_putn),
    .m_dst_full (m_dst_full),
    .m_dst_last (m_dst_last),
    .m_dst_bytes(m_dst_bytes),
    .byte_cnt   (byte_cnt),
    .done       (done),
    .overflow   (overflow)
`ifdef DECODE_OUT_CRC_EN
    ,
    .crc        (crc)
`endif
  );

`ifndef DECODE_OUT_CRC_EN
  assign crc = 32'h0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_word(input logic [63:0] d, input logic [3:0] b, input logic l);
    word_t w;
    w.data = d; w.bytes = b; w.last = l;
    word_q.push_back(w);
  endtask

  task automatic push_done(input logic [19:0] c, input logic [31:0] cr, input logic use_crc);
    done_t e;
    e.cnt = c; e.crc = cr; e.crc_chk = use_crc;
    done_q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic e);
    @(posedge clk);
    #1;
    out_valid = v;
    out_data  = d;
    all_end   = e;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) chk({nm, ".done_timeout"}, 64'd0, 64'd1);
    @(negedge clk);
    chk({nm, ".cnt_cleared"}, 64'(byte_cnt), 64'd0);
  endtask

  // Monitor: every accepted word and every done pulse is checked against the queues.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (m_dst_putn === 1'b0) begin
        if (word_q.size() == 0) begin
          chk("word.unexpected", m_dst, 64'hX);
        end else begin
          word_t w;
          w = word_q.pop_front();
          chk("word.data", m_dst, w.data);
          chk("word.bytes", 64'(m_dst_bytes), 64'(w.bytes));
          chk("word.last", 64'(m_dst_last), 64'(w.last));
        end
      end
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          chk("done.unexpected", 64'(done), 64'd0);
        end else begin
          done_t e;
          e = done_q.pop_front();
          chk("done.byte_cnt", 64'(byte_cnt), 64'(e.cnt));
`ifdef DECODE_OUT_CRC_EN
          if (e.crc_chk) chk("done.crc", 64'(crc), 64'(e.crc));
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          fo_seen;
    bit          fo_prev;
    int          sent;
    int          cyc;
    logic [63:0] w;

    rst = 1'b0; out_valid = 1'b0; out_data = 8'h0; all_end = 1'b0; m_dst_full = 1'b0;

    // Test 1: reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.putn", 64'(m_dst_putn), 64'd1);
    chk("rst.fo_full", 64'(fo_full), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.overflow", 64'(overflow), 64'd0);
    chk("rst.byte_cnt", 64'(byte_cnt), 64'd0);
    @(posedge clk); #1; rst = 1'b1;

    // Test 2: 16 streaming bytes, two full words, putn one cycle after 8th byte
    push_word(64'h0706050403020100, 4'd8, 1'b0);
    push_word(64'h0F0E0D0C0B0A0908, 4'd8, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      @(negedge clk);
      if (i == 7) chk("t2.putn_before_w0", 64'(m_dst_putn), 64'd1);
      if (i == 8) chk("t2.putn_after_w0", 64'(m_dst_putn), 64'd0);
    end
    drive(1'b0, 8'h0, 1'b0);
    @(negedge clk);
    chk("t2.putn_after_w1", 64'(m_dst_putn), 64'd0);
    // Close the stream with an empty terminator
    push_word(64'h0, 4'd0, 1'b1);
    push_done(20'd16, 32'h0, 1'b0);
    drive(1'b0, 8'h0, 1'b1);
    drive(1'b0, 8'h0, 1'b0);
    wait_done("t2");

    // Test 3: short partial word
    push_word(64'h0000000000CCBBAA, 4'd3, 1'b1);
    push_done(20'd3, 32'h0, 1'b0);
    drive(1'b1, 8'hAA, 1'b0);
    drive(1'b1, 8'hBB, 1'b0);
    drive(1'b1, 8'hCC, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    wait_done("t3");

    // Test 4: all_end with 8th byte -> full word then terminator
    push_word(64'h1817161514131211, 4'd8, 1'b0);
    push_word(64'h0, 4'd0, 1'b1);
    push_done(20'd8, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h11 + i), i == 7);
    drive(1'b0, 8'h00, 1'b0);
    wait_done("t4");

    // Test 5: destination full for 30 cycles, source honours fo_full with one cycle lag
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'(8'h20 + k*8 + j);
      push_word(w, 4'd8, 1'b0);
    end
    push_word(64'h0, 4'd0, 1'b1);
    push_done(20'd24, 32'h0, 1'b0);
    fo_seen = 0; fo_prev = 0; sent = 0; cyc = 0;
    while ((sent < 24 || cyc < 30) && cyc < 300) begin
      if (sent < 24 && !fo_prev) begin
        drive(1'b1, 8'(8'h20 + sent), 1'b0);
        sent++;
      end else begin
        drive(1'b0, 8'h00, 1'b0);
      end
      m_dst_full = (cyc < 30);
      cyc++;
      @(negedge clk);
      fo_prev = fo_full;
      if (fo_full) fo_seen = 1;
    end
    chk("t5.all_sent", 64'(sent), 64'd24);
    chk("t5.fo_full_rose", 64'(fo_seen), 64'd1);
    drive(1'b0, 8'h00, 1'b1);
    m_dst_full = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    wait_done("t5");
    chk("t5.overflow", 64'(overflow), 64'd0);

    // Test 6: "123456789" -> CRC check value
    push_word(64'h3837363534333231, 4'd8, 1'b0);
    push_word(64'h0000000000000039, 4'd1, 1'b1);
    push_done(20'd9, 32'hCBF43926, 1'b1);
    for (int i = 0; i < 9; i++) drive(1'b1, 8'(8'h31 + i), 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    wait_done("t6");

    // Test 7: source ignores fo_full while destination stuck -> 17th byte dropped
    m_dst_full = 1'b1;
    for (int i = 0; i < 17; i++) drive(1'b1, 8'(8'h50 + i), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("t7.overflow", 64'(overflow), 64'd1);
    chk("t7.byte_cnt", 64'(byte_cnt), 64'd16);
    chk("t7.fo_full", 64'(fo_full), 64'd1);
    chk("t7.putn_blocked", 64'(m_dst_putn), 64'd1);
    // Mid-operation reset discards the held word
    #1; rst = 1'b0;
    @(negedge clk);
    chk("t7.rst_overflow", 64'(overflow), 64'd0);
    chk("t7.rst_byte_cnt", 64'(byte_cnt), 64'd0);
    chk("t7.rst_fo_full", 64'(fo_full), 64'd0);
    @(posedge clk); #1; rst = 1'b1; m_dst_full = 1'b0;
    repeat (5) @(negedge clk);

    chk("end.words_left", 64'(word_q.size()), 64'd0);
    chk("end.dones_left", 64'(done_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
